// File: rtl/blackjack_ctrl_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : blackjack_ctrl_param_if
//  Purpose  : Bundles the push-button inputs and the display/score outputs
//             of the blackjack controller.
//  Ports    : new_game, hit, stand        - debounced buttons (to controller)
//             phand, dhand, last_card     - hand sums and last card value
//             state_o, result, win_flash  - game state and result display
//             p_wins, d_wins              - saturating win counters
//  Revision : 1.0 - initial release
// ============================================================================
interface blackjack_ctrl_param_if #(
    parameter int HAND_W  = 6,
    parameter int SCORE_W = 8
);
    logic               new_game;
    logic               hit;
    logic               stand;
    logic [HAND_W-1:0]  phand;
    logic [HAND_W-1:0]  dhand;
    logic [HAND_W-1:0]  last_card;
    logic [2:0]         state_o;
    logic [1:0]         result;
    logic               win_flash;
    logic [SCORE_W-1:0] p_wins;
    logic [SCORE_W-1:0] d_wins;

    // Button side: drives the buttons, observes the displays.
    modport master (
        output new_game, hit, stand,
        input  phand, dhand, last_card, state_o, result, win_flash,
               p_wins, d_wins
    );

    // Controller side.
    modport slave (
        input  new_game, hit, stand,
        output phand, dhand, last_card, state_o, result, win_flash,
               p_wins, d_wins
    );
endinterface
`default_nettype wire

// File: rtl/blackjack_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : blackjack_ctrl_param
//  Purpose  : Parametrised blackjack game controller: one player hand, one
//             dealer hand, a free-running card source, deal / player /
//             automatic dealer / compare phases and saturating win counters.
//  Ports    : clk      - system clock, rising edge
//             reset_n  - asynchronous active-low reset
//             bus      - slave modport of blackjack_ctrl_param_if
//                        (buttons in, hands/state/result/scores out)
//  Revision : 1.0 - initial release
// ============================================================================
module blackjack_ctrl_param #(
    parameter int HAND_W       = 6,
    parameter int CARD_MAX     = 10,
    parameter int BUST_LIMIT   = 21,
    parameter int DEALER_STAND = 17,
    parameter int SCORE_W      = 8,
    parameter int FLASH_DIV    = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    blackjack_ctrl_param_if.slave      bus
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_DEAL    = 3'd1;
    localparam logic [2:0] c_PLAYER  = 3'd2;
    localparam logic [2:0] c_DEALER  = 3'd3;
    localparam logic [2:0] c_COMPARE = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    localparam logic [1:0] c_RES_NONE = 2'b00;
    localparam logic [1:0] c_RES_PWIN = 2'b01;
    localparam logic [1:0] c_RES_DWIN = 2'b10;
    localparam logic [1:0] c_RES_PUSH = 2'b11;

    localparam int                c_FDW        = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [c_FDW-1:0]  c_FLASH_LAST = c_FDW'(FLASH_DIV - 1);
    localparam logic [HAND_W-1:0] c_CARD_MAX   = HAND_W'(CARD_MAX);
    localparam logic [HAND_W-1:0] c_BUST       = HAND_W'(BUST_LIMIT);
    localparam logic [HAND_W-1:0] c_STAND      = HAND_W'(DEALER_STAND);
    localparam logic [HAND_W-1:0] c_ONE        = HAND_W'(1);

    logic [2:0]         state_q,     state_d;
    logic [1:0]         step_q,      step_d;
    logic [HAND_W-1:0]  ctr_q,       ctr_d;
    logic [HAND_W-1:0]  phand_q,     phand_d;
    logic [HAND_W-1:0]  dhand_q,     dhand_d;
    logic [HAND_W-1:0]  last_card_q, last_card_d;
    logic [1:0]         result_q,    result_d;
    logic               flash_q,     flash_d;
    logic [c_FDW-1:0]   flash_cnt_q, flash_cnt_d;
    logic [SCORE_W-1:0] p_wins_q,    p_wins_d;
    logic [SCORE_W-1:0] d_wins_q,    d_wins_d;
    logic               ng_prev_q,   ng_prev_d;
    logic               hit_prev_q,  hit_prev_d;
    logic               stand_prev_q, stand_prev_d;

    logic               w_ng_edge;
    logic               w_hit_edge;
    logic               w_stand_edge;
    logic               w_start;
    logic               w_enter_done;
    logic [1:0]         w_new_result;
    logic [HAND_W-1:0]  w_psum;
    logic [HAND_W-1:0]  w_dsum;

    function automatic logic [HAND_W-1:0] sat_add(input logic [HAND_W-1:0] a,
                                                  input logic [HAND_W-1:0] b);
        logic [HAND_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[HAND_W] ? {HAND_W{1'b1}} : s[HAND_W-1:0];
    endfunction

    assign w_ng_edge    = bus.new_game & ~ng_prev_q;
    assign w_hit_edge   = bus.hit      & ~hit_prev_q;
    assign w_stand_edge = bus.stand    & ~stand_prev_q;
    assign w_psum       = sat_add(phand_q, ctr_q);
    assign w_dsum       = sat_add(dhand_q, ctr_q);

    // A new round may start (or abort the current one) from every state
    // except the single-cycle COMPARE and the unused encodings.
    assign w_start = w_ng_edge && (state_q inside {c_IDLE, c_DEAL, c_PLAYER, c_DEALER, c_DONE});

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        ctr_d        = (ctr_q == c_CARD_MAX) ? c_ONE : ctr_q + c_ONE;
        phand_d      = phand_q;
        dhand_d      = dhand_q;
        last_card_d  = last_card_q;
        result_d     = result_q;
        flash_d      = flash_q;
        flash_cnt_d  = flash_cnt_q;
        p_wins_d     = p_wins_q;
        d_wins_d     = d_wins_q;
        ng_prev_d    = bus.new_game;
        hit_prev_d   = bus.hit;
        stand_prev_d = bus.stand;
        w_enter_done = 1'b0;
        w_new_result = c_RES_NONE;

        if (w_start) begin
            state_d     = c_DEAL;
            step_d      = 2'd0;
            phand_d     = '0;
            dhand_d     = '0;
            result_d    = c_RES_NONE;
            flash_d     = 1'b0;
            flash_cnt_d = '0;
        end else begin
            case (state_q)
                c_IDLE: ;
                c_DEAL: begin
                    // Even steps feed the player, odd steps the dealer.
                    if (!step_q[0]) phand_d = w_psum;
                    else            dhand_d = w_dsum;
                    last_card_d = ctr_q;
                    step_d      = step_q + 2'd1;
                    if (step_q == 2'd3) state_d = c_PLAYER;
                end
                c_PLAYER: begin
                    // Stand has priority over a simultaneous hit.
                    if (w_stand_edge) begin
                        state_d = c_DEALER;
                    end else if (w_hit_edge) begin
                        phand_d     = w_psum;
                        last_card_d = ctr_q;
                        if (w_psum > c_BUST) begin
                            w_enter_done = 1'b1;
                            w_new_result = c_RES_DWIN;
                        end
                    end
                end
                c_DEALER: begin
                    if (dhand_q < c_STAND) begin
                        dhand_d     = w_dsum;
                        last_card_d = ctr_q;
                    end else begin
                        state_d = c_COMPARE;
                    end
                end
                c_COMPARE: begin
                    w_enter_done = 1'b1;
                    if (dhand_q > c_BUST)         w_new_result = c_RES_PWIN;
                    else if (phand_q > dhand_q)   w_new_result = c_RES_PWIN;
                    else if (phand_q == dhand_q)  w_new_result = c_RES_PUSH;
                    else                          w_new_result = c_RES_DWIN;
                end
                c_DONE: begin
                    if (result_q == c_RES_PWIN) begin
                        if (flash_cnt_q == c_FLASH_LAST) begin
                            flash_cnt_d = '0;
                            flash_d     = ~flash_q;
                        end else begin
                            flash_cnt_d = flash_cnt_q + c_FDW'(1);
                        end
                    end
                end
                default: state_d = c_IDLE;
            endcase
        end

        if (w_enter_done) begin
            state_d     = c_DONE;
            result_d    = w_new_result;
            flash_cnt_d = '0;
            flash_d     = (w_new_result == c_RES_PWIN) || (w_new_result == c_RES_DWIN);
            if ((w_new_result == c_RES_PWIN) && (p_wins_q != {SCORE_W{1'b1}}))
                p_wins_d = p_wins_q + SCORE_W'(1);
            if ((w_new_result == c_RES_DWIN) && (d_wins_q != {SCORE_W{1'b1}}))
                d_wins_d = d_wins_q + SCORE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= c_IDLE;
            step_q       <= 2'd0;
            ctr_q        <= c_ONE;
            phand_q      <= '0;
            dhand_q      <= '0;
            last_card_q  <= '0;
            result_q     <= c_RES_NONE;
            flash_q      <= 1'b0;
            flash_cnt_q  <= '0;
            p_wins_q     <= '0;
            d_wins_q     <= '0;
            ng_prev_q    <= 1'b0;
            hit_prev_q   <= 1'b0;
            stand_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            ctr_q        <= ctr_d;
            phand_q      <= phand_d;
            dhand_q      <= dhand_d;
            last_card_q  <= last_card_d;
            result_q     <= result_d;
            flash_q      <= flash_d;
            flash_cnt_q  <= flash_cnt_d;
            p_wins_q     <= p_wins_d;
            d_wins_q     <= d_wins_d;
            ng_prev_q    <= ng_prev_d;
            hit_prev_q   <= hit_prev_d;
            stand_prev_q <= stand_prev_d;
        end
    end

    assign bus.phand     = phand_q;
    assign bus.dhand     = dhand_q;
    assign bus.last_card = last_card_q;
    assign bus.state_o   = state_q;
    assign bus.result    = result_q;
    assign bus.win_flash = flash_q;
    assign bus.p_wins    = p_wins_q;
    assign bus.d_wins    = d_wins_q;

endmodule
`default_nettype wire

// File: tb/tb_blackjack_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blackjack_ctrl_param
//  Purpose  : Directed self-checking bench for blackjack_ctrl_param. Two
//             instances share the same buttons: one with 8-bit win counters
//             and one with 2-bit counters to exercise saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blackjack_ctrl_param;

    localparam int CARD_MAX  = 10;
    localparam int BUST      = 21;
    localparam int DSTAND    = 17;
    localparam int FLASH_DIV = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    blackjack_ctrl_param_if #(.HAND_W(6), .SCORE_W(8)) bus_a ();
    blackjack_ctrl_param_if #(.HAND_W(6), .SCORE_W(2)) bus_b ();

    assign bus_b.new_game = bus_a.new_game;
    assign bus_b.hit      = bus_a.hit;
    assign bus_b.stand    = bus_a.stand;

    blackjack_ctrl_param #(.HAND_W(6), .CARD_MAX(CARD_MAX), .BUST_LIMIT(BUST),
        .DEALER_STAND(DSTAND), .SCORE_W(8), .FLASH_DIV(FLASH_DIV))
    u_dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

    blackjack_ctrl_param #(.HAND_W(6), .CARD_MAX(CARD_MAX), .BUST_LIMIT(BUST),
        .DEALER_STAND(DSTAND), .SCORE_W(2), .FLASH_DIV(FLASH_DIV))
    u_dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model of the game.
    int m_ctr, mp, md, m_last, m_state, m_res, pw, dw;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0d expected=<entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic push_all();
        push("state_o",   m_state);
        push("phand",     mp);
        push("dhand",     md);
        push("last_card", m_last);
        push("result",    m_res);
        push("p_wins_a",  pw);
        push("d_wins_a",  dw);
        push("p_wins_b",  (pw > 3) ? 3 : pw);
        push("d_wins_b",  (dw > 3) ? 3 : dw);
    endtask

    task automatic pop_all();
        pop_chk(bus_a.state_o);
        pop_chk(bus_a.phand);
        pop_chk(bus_a.dhand);
        pop_chk(bus_a.last_card);
        pop_chk(bus_a.result);
        pop_chk(bus_a.p_wins);
        pop_chk(bus_a.d_wins);
        pop_chk(bus_b.p_wins);
        pop_chk(bus_b.d_wins);
    endtask

    // Advance one clock; m_ctr then equals the card value of the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        m_ctr = (m_ctr == CARD_MAX) ? 1 : m_ctr + 1;
    endtask

    task automatic wait_ctr(input int v);
        for (int n = 0; n < CARD_MAX + 2 && m_ctr != v; n++) tick();
    endtask

    task automatic begin_round();
        bus_a.new_game = 1'b1;
        m_state = 1; mp = 0; md = 0; m_res = 0;
        push_all();
        tick();
        bus_a.new_game = 1'b0;
        pop_all();
    endtask

    task automatic finish_deal();
        for (int s = 0; s < 4; s++) begin
            if (s % 2 == 0) mp += m_ctr;
            else            md += m_ctr;
            m_last = m_ctr;
            if (s == 3) begin
                m_state = 2;
                push_all();
            end
            tick();
        end
        pop_all();
    endtask

    task automatic hit_model();
        mp += m_ctr;
        m_last = m_ctr;
        if (mp > BUST) begin
            m_state = 5; m_res = 2; dw++;
        end
    endtask

    task automatic do_hit();
        bus_a.hit = 1'b1;
        hit_model();
        push_all();
        tick();
        bus_a.hit = 1'b0;
        pop_all();
        tick();
    endtask

    task automatic hold_hit(input int cycles);
        bus_a.hit = 1'b1;
        hit_model();
        push_all();
        repeat (cycles) tick();
        bus_a.hit = 1'b0;
        tick();
        pop_all();
    endtask

    task automatic do_stand(input logic with_hit);
        bus_a.stand = 1'b1;
        bus_a.hit   = with_hit;
        m_state = 3;
        push_all();
        tick();
        bus_a.stand = 1'b0;
        bus_a.hit   = 1'b0;
        pop_all();
    endtask

    task automatic run_dealer();
        bit stopped = 0;
        for (int n = 0; n < 30 && !stopped; n++) begin
            if (md < DSTAND) begin
                md += m_ctr;
                m_last = m_ctr;
                tick();
            end else begin
                m_state = 4;
                tick();
                stopped = 1;
            end
        end
        if (!stopped) begin
            checks++;
            errors++;
            $error("FAIL dealer_timeout: observed=running expected=stopped");
        end
        if (md > BUST)      m_res = 1;
        else if (mp > md)   m_res = 1;
        else if (mp == md)  m_res = 3;
        else                m_res = 2;
        if (m_res == 1) pw++;
        if (m_res == 2) dw++;
        m_state = 5;
        push_all();
        push("win_flash_entry", (m_res == 1 || m_res == 2) ? 1 : 0);
        tick();
        pop_all();
        pop_chk(bus_a.win_flash);
    endtask

    task automatic check_flash_pattern();
        // Entry cycle counts as k=0; level holds FLASH_DIV clocks per phase.
        for (int k = 0; k < 2 * FLASH_DIV; k++)
            push("win_flash_toggle", ((k / FLASH_DIV) % 2 == 0) ? 1 : 0);
        for (int k = 0; k < 2 * FLASH_DIV; k++) begin
            if (k != 0) tick();
            pop_chk(bus_a.win_flash);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.new_game = 1'b0;
        bus_a.hit      = 1'b0;
        bus_a.stand    = 1'b0;
        m_ctr = 1; mp = 0; md = 0; m_last = 0; m_state = 0; m_res = 0; pw = 0; dw = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ctr = 1;
        push_all();
        push("win_flash_reset", 0);
        pop_all();
        pop_chk(bus_a.win_flash);

        // Deal: new_game seen at ctr 1, first DEAL cycle ctr 2 -> p=6 d=8
        wait_ctr(1);
        begin_round();
        finish_deal();

        // Player bust: hits at 9 and 8 -> 15, 23
        wait_ctr(9); do_hit();
        wait_ctr(8); do_hit();
        push("win_flash_dwin", 1);
        pop_chk(bus_a.win_flash);

        // Dealer stops at 19, player 20 wins; flash toggles
        wait_ctr(1); begin_round(); finish_deal();
        wait_ctr(9); do_hit();
        wait_ctr(5); do_hit();
        wait_ctr(4); do_stand(1'b0);
        run_dealer();
        check_flash_pattern();

        // Dealer overshoots to 25
        wait_ctr(1); begin_round(); finish_deal();
        wait_ctr(9); do_hit();
        wait_ctr(5); do_hit();
        wait_ctr(7); do_stand(1'b0);
        run_dealer();

        // Push at 18/18
        wait_ctr(1); begin_round(); finish_deal();
        wait_ctr(9); do_hit();
        wait_ctr(3); do_hit();
        wait_ctr(9); do_stand(1'b0);
        run_dealer();
        push("win_flash_push", 0);
        tick();
        pop_chk(bus_a.win_flash);

        // Simultaneous hit+stand: stand wins
        wait_ctr(1); begin_round(); finish_deal();
        do_stand(1'b1);
        run_dealer();

        // Abort from PLAYER, then a held hit draws one card
        wait_ctr(1); begin_round(); finish_deal();
        begin_round();
        finish_deal();
        hold_hit(10);
        if (m_state == 2) begin
            do_stand(1'b0);
            run_dealer();
        end

        // Extra player wins to saturate the 2-bit counters
        for (int r = 0; r < 3; r++) begin
            wait_ctr(1); begin_round(); finish_deal();
            wait_ctr(7); do_stand(1'b0);
            run_dealer();
        end

        // Asynchronous reset in the middle of the dealer turn
        wait_ctr(1); begin_round(); finish_deal();
        wait_ctr(7); do_stand(1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        mp = 0; md = 0; m_last = 0; m_state = 0; m_res = 0; pw = 0; dw = 0;
        push_all();
        push("win_flash_async_reset", 0);
        pop_all();
        pop_chk(bus_a.win_flash);
        tick();
        reset_n = 1'b1;
        m_ctr = 1;
        push("state_after_reset", 0);
        tick();
        pop_chk(bus_a.state_o);

        if (q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blackjack_ctrl_param.md
Name: blackjack_ctrl_param

Overview:
Parametrised, fully synchronous blackjack game controller for the board-level game. It holds one player hand and one dealer hand and an on-chip card source. It runs deal, player-turn, automatic dealer-turn and compare phases, and keeps saturating win counters across rounds. It sits between the debounced push-button inputs and the LED/HEX display drivers.

Parameters:
HAND_W, 6, width of hand sums (must hold BUST_LIMIT+CARD_MAX)
CARD_MAX, 10, card values are 1..CARD_MAX
BUST_LIMIT, 21, a hand strictly above this value is bust
DEALER_STAND, 17, dealer keeps drawing while dhand < DEALER_STAND
SCORE_W, 8, width of the win counters
FLASH_DIV, 4, win_flash toggle period in clocks

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  reset; asynchronous, active-low
new_game  in  1  active-high level, debounced; its rising edge starts a round
hit  in  1  active-high level, debounced; its rising edge draws a player card
stand  in  1  active-high level, debounced; its rising edge ends the player turn
phand  out  HAND_W  player hand sum
dhand  out  HAND_W  dealer hand sum
last_card  out  HAND_W  value of the most recent card dealt
state_o  out  3  current state encoding
result  out  2  00 none, 01 player win, 10 dealer win, 11 push
win_flash  out  1  toggles when result=01; 1 when result=10; 0 otherwise
p_wins  out  SCORE_W  player round wins, saturating
d_wins  out  SCORE_W  dealer round wins, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE; phand, dhand, last_card, result, win_flash, p_wins and d_wins all 0; card counter ctr=1.
- ctr increments every clock and wraps from CARD_MAX to 1. A card drawn in cycle N has value ctr(N).
- Inputs are edge-detected internally from a registered previous value. An action is taken in the cycle its edge is seen; sums update at the next clock edge, i.e. 1-cycle latency.
- States and encodings:
  - IDLE=0
  - DEAL=1
  - PLAYER=2
  - DEALER=3
  - COMPARE=4
  - DONE=5
- IDLE: new_game edge -> DEAL.
- DEAL: lasts 4 cycles using an internal 2-bit step count, dealing P, D, P, D. Each step adds ctr to the respective hand. Then -> PLAYER.
- PLAYER:
  - hit edge: phand += card.
  - If the new phand > BUST_LIMIT -> DONE with result=10.
  - stand edge -> DEALER.
  - hit and stand edges in the same cycle: stand wins, hit is ignored.
- DEALER: if dhand < DEALER_STAND, draw one card per clock into dhand; otherwise -> COMPARE. No user input is needed.
- COMPARE (1 cycle), first matching rule applies:
  - dhand > BUST_LIMIT -> result 01
  - phand > dhand -> 01
  - phand == dhand -> 11
  - else -> 10
  - Then -> DONE.
- Entering DONE: result is registered. p_wins increments on 01; d_wins increments on 10; a push increments neither. Both counters saturate at all-ones.
- DONE: hands and result are held; new_game edge -> DEAL.
- new_game edge in DEAL, PLAYER or DEALER aborts the round:
  - phand, dhand and result cleared
  - next state DEAL
  - win counters unchanged
- From DONE, phand, dhand and result are cleared in the same cycle as entering DEAL.
- Hand sums saturate at 2^HAND_W-1; with the defaults, saturation is unreachable.
- win_flash in DONE:
  - result 01: toggles every FLASH_DIV clocks, starting at 1 on DONE entry.
  - result 10: constant 1.
  - Otherwise: 0.
- Reset mid-round clears everything immediately, including the win counters.
- Any unused state encoding -> IDLE on the next clock.

Test Plan:
1. Deal: reset, then new_game edge with ctr=2 on the first DEAL cycle -> after 4 cycles phand=6 (2+4), dhand=8 (3+5), state_o=2.
2. Player bust: from case 1, hit edges at ctr values 9 and 8 -> phand=15, then 23 -> state_o=5, result=10, d_wins=1, win_flash=1.
3. Dealer auto-draw and bust:
   - Start with phand=20 and dhand=8, then stand.
   - Dealer draws on consecutive cycles with ctr=5 -> 13, then ctr=6 -> 19, and stops since 19 >= 17.
   - Compare gives 20 > 19 -> result=01, p_wins=1, win_flash toggles every 4 clocks.
   - Repeat with draws that overshoot to 25 -> result=01.
4. Push: phand=18 and dhand=18 after the dealer stops -> result=11, p_wins and d_wins unchanged.
5. Priority and abort:
   - hit and stand edges in the same cycle -> phand unchanged, state_o=3.
   - new_game edge while in PLAYER -> hands cleared, state_o=1 next cycle, counters retained.
   - Holding hit high for 10 cycles draws exactly 1 card.
6. Saturation and reset:
   - With SCORE_W=2, 4 player wins -> p_wins=3.
   - Assert reset_n low mid-DEALER -> all outputs 0 asynchronously, without waiting for a clock edge.
